// File: rtl/sa_pkg.sv
// Shared constants and state encoding for the systolic-array data-setup stage.
package sa_pkg;
  localparam int SA_ROWS = 8;
  localparam int SA_DW   = 8;

  typedef enum logic [1:0] {DS_IDLE, DS_STREAM, DS_DRAIN} ds_state_t;
endpackage

// File: rtl/sa_skew_line.sv
// Fixed-length register delay line carrying a {valid,data} pair; output is the last stage.
module sa_skew_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  output logic          tap_valid,
  output logic [DW-1:0] tap_data
);
  logic [DW:0] stage_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= {src_valid, src_data};
      for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign {tap_valid, tap_data} = stage_reg[DEPTH-1];
endmodule

// File: rtl/sa_data_setup.sv
// Data-setup stage feeding the systolic array: diagonal skew of each accepted
// vector plus the stream/drain handshake with the SA controller.
module sa_data_setup
  import sa_pkg::*;
#(
  parameter int ROWS = SA_ROWS,
  parameter int DW   = SA_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_enable,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*DW-1:0]   in_data,
  input  logic                 in_last,
  output logic [ROWS*DW-1:0]   sa_data,
  output logic [ROWS-1:0]      sa_valid,
  output logic                 d_valid,
  output logic                 data_last
);
  localparam int CW = $clog2(ROWS) + 1;

  ds_state_t     state_reg, state_next;
  logic [CW-1:0] drain_cnt_reg, drain_cnt_next;
  logic          accept;

  assign accept  = in_valid && in_ready;
  assign d_valid = |sa_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= DS_IDLE;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    in_ready       = 1'b0;
    data_last      = 1'b0;
    case (state_reg)
      DS_IDLE: begin
        if (data_enable) state_next = DS_STREAM;
      end
      DS_STREAM: begin
        in_ready = data_enable;
        if (data_enable && in_valid && in_last) begin
          state_next     = DS_DRAIN;
          drain_cnt_next = CW'(ROWS - 1);
        end else if (!data_enable && (sa_valid == '0)) begin
          // Any vector still in the skew shows on at least one row, so an
          // all-clear sa_valid means nothing is in flight.
          state_next = DS_IDLE;
        end
      end
      DS_DRAIN: begin
        if (drain_cnt_reg == '0) begin
          data_last  = 1'b1;
          state_next = DS_IDLE;
        end else begin
          drain_cnt_next = drain_cnt_reg - CW'(1);
        end
      end
      default: state_next = DS_IDLE;
    endcase
  end

  // Row gi is delayed gi+1 register stages; non-accept cycles inject zero bubbles.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    sa_skew_line #(
      .DEPTH(gi + 1),
      .DW   (DW)
    ) u_line (
      .clk      (clk),
      .rst      (rst),
      .src_valid(accept),
      .src_data (accept ? in_data[gi*DW +: DW] : '0),
      .tap_valid(sa_valid[gi]),
      .tap_data (sa_data[gi*DW +: DW])
    );
  end
endmodule

// File: tb/tb_sa_data_setup.sv
// Scoreboard bench for sa_data_setup with ROWS=4, DW=8 directed streams.
module tb_sa_data_setup;
  localparam int ROWS = 4;
  localparam int DW   = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 data_enable;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_data;
  logic                 in_last;
  logic [ROWS*DW-1:0]   sa_data;
  logic [ROWS-1:0]      sa_valid;
  logic                 d_valid;
  logic                 data_last;

  sa_data_setup #(.ROWS(ROWS), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_enable(data_enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .sa_data    (sa_data),
    .sa_valid   (sa_valid),
    .d_valid    (d_valid),
    .data_last  (data_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int             cyc;
    logic [DW-1:0]  data;
  } exp_t;

  exp_t rq [ROWS][$];
  exp_t lq [$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: pops the expected row/last entries whenever the DUT presents them.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check("d_valid_or", 64'(d_valid), 64'(|sa_valid));
      for (int r = 0; r < ROWS; r++) begin
        while (rq[r].size() > 0 && rq[r][0].cyc < cyc) begin
          e = rq[r].pop_front();
          check($sformatf("row%0d_missing_at", r), 64'(cyc), 64'(e.cyc));
        end
        if (sa_valid[r]) begin
          if (rq[r].size() == 0) begin
            check($sformatf("row%0d_unexpected_valid", r), 64'(1), 64'(0));
          end else begin
            e = rq[r].pop_front();
            check($sformatf("row%0d_cycle", r), 64'(cyc), 64'(e.cyc));
            check($sformatf("row%0d_data", r), 64'(sa_data[r*DW +: DW]), 64'(e.data));
          end
        end
      end
      while (lq.size() > 0 && lq[0].cyc < cyc) begin
        e = lq.pop_front();
        check("data_last_missing_at", 64'(cyc), 64'(e.cyc));
      end
      if (data_last) begin
        if (lq.size() == 0) begin
          check("data_last_unexpected", 64'(1), 64'(0));
        end else begin
          e = lq.pop_front();
          check("data_last_cycle", 64'(cyc), 64'(e.cyc));
          check("data_last_row3", 64'(sa_data[(ROWS-1)*DW +: DW]), 64'(e.data));
          check("data_last_valid3", 64'(sa_valid[ROWS-1]), 64'(1));
          check("data_last_d_valid", 64'(d_valid), 64'(1));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Present vector k (row r = 8'h10*k + r); row r expected at the next cycle + r.
  task automatic drive_vec(input int k, input bit last);
    in_valid = 1'b1;
    in_last  = last;
    for (int r = 0; r < ROWS; r++) in_data[r*DW +: DW] = 8'(16 * k + r);
    #1;
    check("in_ready_accept", 64'(in_ready), 64'(1));
    for (int r = 0; r < ROWS; r++) rq[r].push_back('{cyc + 1 + r, 8'(16 * k + r)});
  endtask

  initial begin
    int base;
    rst = 1'b1;
    data_enable = 1'b0;
    idle_in();
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_sa_valid", 64'(sa_valid), 64'(0));
    check("rst_sa_data", 64'(sa_data), 64'(0));
    check("rst_d_valid", 64'(d_valid), 64'(0));
    check("rst_data_last", 64'(data_last), 64'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    // Idle with in_valid but no data_enable: nothing is accepted.
    in_valid = 1'b1;
    in_data  = '1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_in_ready", 64'(in_ready), 64'(0));
      check("idle_sa_valid", 64'(sa_valid), 64'(0));
    end
    idle_in();

    // Three back-to-back vectors, last on vector 2.
    tick(); data_enable = 1'b1;
    tick(); base = cyc; drive_vec(0, 1'b0);
    tick(); drive_vec(1, 1'b0);
    tick(); drive_vec(2, 1'b1); lq.push_back('{base + 6, 8'h23});
    tick(); idle_in(); #1;
    check("drain_in_ready", 64'(in_ready), 64'(0));
    wait_until(base + 7);
    check("t1_idle_at_7", 64'(in_ready), 64'(0));
    tick();
    check("t1_stream_at_8", 64'(in_ready), 64'(1));
    data_enable = 1'b0;
    tick();

    // Same stream with a bubble on cycle 1.
    tick(); data_enable = 1'b1;
    tick(); base = cyc; drive_vec(0, 1'b0);
    tick(); idle_in();
    tick(); drive_vec(1, 1'b0);
    tick(); drive_vec(2, 1'b1); lq.push_back('{base + 7, 8'h23});
    tick(); idle_in();
    wait_until(base + 8);
    check("t2_idle_at_8", 64'(in_ready), 64'(0));
    data_enable = 1'b0;
    tick();

    // Single vector with in_last.
    tick(); data_enable = 1'b1;
    tick(); base = cyc; drive_vec(0, 1'b1); lq.push_back('{base + 4, 8'h03});
    tick(); idle_in();
    check("onehot_c1", 64'(sa_valid), 64'(4'b0001));
    tick(); check("onehot_c2", 64'(sa_valid), 64'(4'b0010));
    tick(); check("onehot_c3", 64'(sa_valid), 64'(4'b0100));
    tick(); check("onehot_c4", 64'(sa_valid), 64'(4'b1000));
    check("single_last_c4", 64'(data_last), 64'(1));
    tick();
    check("t3_idle_at_5", 64'(in_ready), 64'(0));
    check("t3_no_last_c5", 64'(data_last), 64'(0));
    data_enable = 1'b0;
    tick();

    // data_enable dropped mid-stream after two vectors.
    tick(); data_enable = 1'b1;
    tick(); base = cyc; drive_vec(4, 1'b0);
    tick(); drive_vec(5, 1'b0);
    tick(); data_enable = 1'b0; in_valid = 1'b1; in_last = 1'b1; #1;
    check("de_drop_in_ready", 64'(in_ready), 64'(0));
    while (cyc < base + 10) begin
      tick();
      check("de_drop_hold_ready", 64'(in_ready), 64'(0));
    end
    idle_in(); data_enable = 1'b1; #1;
    check("t4_idle_at_10", 64'(in_ready), 64'(0));
    tick();
    check("t4_stream_at_11", 64'(in_ready), 64'(1));
    data_enable = 1'b0;
    tick();

    // Reset during DRAIN when drain_cnt==2.
    tick(); data_enable = 1'b1;
    tick(); base = cyc; drive_vec(6, 1'b1);
    tick(); idle_in();
    tick(); rst = 1'b1;
    rq[2].delete();
    rq[3].delete();
    tick(); rst = 1'b0; #1;
    check("rst_drain_sa_valid", 64'(sa_valid), 64'(0));
    check("rst_drain_sa_data", 64'(sa_data), 64'(0));
    check("rst_drain_d_valid", 64'(d_valid), 64'(0));
    check("rst_drain_data_last", 64'(data_last), 64'(0));
    check("rst_drain_in_ready", 64'(in_ready), 64'(0));
    tick();
    check("rst_drain_stream_next", 64'(in_ready), 64'(1));
    data_enable = 1'b0;
    repeat (8) tick();

    for (int r = 0; r < ROWS; r++) check($sformatf("row%0d_queue_left", r), 64'(rq[r].size()), 64'(0));
    check("last_queue_left", 64'(lq.size()), 64'(0));
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
